axi_to_video_reader: RTL and testbench

AXI_TO_VIDEO_READER -- requirements
Module: axi_to_video_reader

---
 rtl/axi_to_video_reader.sv | 190 +++++++++++++++++++
 tb/tb_axi_to_video_reader.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_to_video_reader.sv
// axi_to_video_reader: fetches one frame of pixels from memory with AXI4 INCR
// read bursts and streams it as AXI4-Stream video (tuser = start of frame,
// tlast = last pixel of frame) through a first-word-fall-through pixel FIFO.
//
// Handshakes: every channel (AR, R, m_axis) transfers on a rising clock edge
// where valid and ready are both high. A source that raises valid holds it and
// its payload stable until that edge. Valid never waits on ready.
module axi_to_video_reader #(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int PIXEL_WIDTH    = 24,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int BURST_LEN      = 16,
   parameter int FRAME_PIXELS   = 1024,
   parameter int FIFO_DEPTH     = 32
) (
   input  logic                      axis_video_aclk,
   input  logic                      axis_video_aresetn,
   input  logic                      start,
   input  logic [AXI_ADDR_WIDTH-1:0] frame_base_addr,
   output logic [AXI_ADDR_WIDTH-1:0] araddr,
   output logic [7:0]                arlen,
   output logic [2:0]                arsize,
   output logic [1:0]                arburst,
   output logic                      arvalid,
   input  logic                      arready,
   input  logic [AXI_DATA_WIDTH-1:0] rdata,
   input  logic [1:0]                rresp,
   input  logic                      rlast,
   input  logic                      rvalid,
   output logic                      rready,
   output logic [PIXEL_WIDTH-1:0]    m_axis_tdata,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic                      m_axis_tuser,
   output logic                      m_axis_tlast,
   output logic                      busy,
   output logic                      frame_done,
   output logic                      rresp_err
);

   localparam int BYTES_PER_BEAT = AXI_DATA_WIDTH / 8;
   localparam int NUM_BURSTS     = FRAME_PIXELS / BURST_LEN;
   localparam int BEAT_W         = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int BURST_W        = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
   localparam int PIX_W          = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
   localparam int PTR_W          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W          = $clog2(FIFO_DEPTH + 1);

   localparam logic [BEAT_W-1:0]         BEAT_LAST   = BEAT_W'(BURST_LEN - 1);
   localparam logic [BURST_W-1:0]        BURST_LAST  = BURST_W'(NUM_BURSTS - 1);
   localparam logic [PIX_W-1:0]          PIX_LAST    = PIX_W'(FRAME_PIXELS - 1);
   // A burst may only be requested when the whole burst is guaranteed to fit.
   localparam logic [CNT_W-1:0]          AR_THRESH   = CNT_W'(FIFO_DEPTH - BURST_LEN);
   localparam logic [AXI_ADDR_WIDTH-1:0] BURST_BYTES = AXI_ADDR_WIDTH'(BURST_LEN * BYTES_PER_BEAT);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

   state_t               state;
   logic [BEAT_W-1:0]    beat_cnt;
   logic [BURST_W-1:0]   burst_cnt;
   logic [PIX_W-1:0]     pix_cnt;
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]     fifo_cnt;
   logic [PIXEL_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

   logic push;
   logic pop;
   logic last_beat;
   logic last_burst;
   logic last_pix;
   logic unused_rdata_bits;

   // Fixed burst shape.
   assign arlen   = 8'(BURST_LEN - 1);
   assign arsize  = 3'($clog2(BYTES_PER_BEAT));
   assign arburst = 2'b01;

   assign rready        = (state == DATA);
   assign busy          = (state != IDLE);
   assign push          = rvalid && rready;
   assign m_axis_tvalid = (fifo_cnt != '0);
   assign pop           = m_axis_tvalid && m_axis_tready;
   assign last_beat     = (beat_cnt == BEAT_LAST);
   assign last_burst    = (burst_cnt == BURST_LAST);
   assign last_pix      = (pix_cnt == PIX_LAST);

   assign m_axis_tdata  = fifo_mem[rd_ptr];
   assign m_axis_tuser  = m_axis_tvalid && (pix_cnt == '0);
   assign m_axis_tlast  = m_axis_tvalid && last_pix;
   // The last pixel can only leave after the final beat, so it always pops in DRAIN.
   assign frame_done    = (state == DRAIN) && pop && last_pix;

   // Only the pixel bits of each beat are kept.
   assign unused_rdata_bits = ^rdata;

   // Control FSM: burst address generation, beat counting and error capture.
   always_ff @(posedge axis_video_aclk or negedge axis_video_aresetn) begin
      if (!axis_video_aresetn) begin
         state     <= IDLE;
         arvalid   <= 1'b0;
         araddr    <= '0;
         beat_cnt  <= '0;
         burst_cnt <= '0;
         rresp_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  araddr    <= frame_base_addr;
                  beat_cnt  <= '0;
                  burst_cnt <= '0;
                  rresp_err <= 1'b0;
                  state     <= ADDR;
               end
            end
            ADDR: begin
               if (arvalid) begin
                  if (arready) begin
                     arvalid <= 1'b0;
                     state   <= DATA;
                  end
               end else if (fifo_cnt <= AR_THRESH) begin
                  arvalid <= 1'b1;
               end
            end
            DATA: begin
               if (push) begin
                  if ((rresp != 2'b00) || (rlast != last_beat)) begin
                     rresp_err <= 1'b1;
                  end
                  if (last_beat) begin
                     beat_cnt <= '0;
                     araddr   <= araddr + BURST_BYTES;
                     if (last_burst) begin
                        state <= DRAIN;
                     end else begin
                        burst_cnt <= burst_cnt + BURST_W'(1);
                        state     <= ADDR;
                     end
                  end else begin
                     beat_cnt <= beat_cnt + BEAT_W'(1);
                  end
               end
            end
            DRAIN: begin
               if (frame_done) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // FIFO pointers, occupancy and the output pixel position within the frame.
   always_ff @(posedge axis_video_aclk or negedge axis_video_aresetn) begin
      if (!axis_video_aresetn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         pix_cnt  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
         if ((state == IDLE) && start) begin
            pix_cnt <= '0;
         end else if (pop) begin
            pix_cnt <= last_pix ? '0 : pix_cnt + PIX_W'(1);
         end
      end
   end

   // Pixel storage; writes never land on the head entry while it is being shown.
   always_ff @(posedge axis_video_aclk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= rdata[PIXEL_WIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_axi_to_video_reader.sv
// tb_axi_to_video_reader: drives axi_to_video_reader with an AXI read slave
// backed by a random memory image and a video sink, and compares everything
// against a frame-level model (expected pixel queue, handshake counts).
`timescale 1ns/1ps
module tb_axi_to_video_reader;

   localparam int AXI_DATA_WIDTH = 32;
   localparam int PIXEL_WIDTH    = 24;
   localparam int AXI_ADDR_WIDTH = 32;
   localparam int BURST_LEN      = 16;
   localparam int FRAME_PIXELS   = 1024;
   localparam int FIFO_DEPTH     = 32;
   localparam int BURST_BYTES    = BURST_LEN * AXI_DATA_WIDTH / 8;
   localparam int NUM_BURSTS     = FRAME_PIXELS / BURST_LEN;
   localparam logic [31:0] MEM_BASE = 32'h1000_0000;
   localparam int MEM_WORDS      = 4096;

   // ---------------- clock / reset ----------------
   logic clk;
   logic aresetn;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic                      start;
   logic [AXI_ADDR_WIDTH-1:0] frame_base_addr;
   logic [AXI_ADDR_WIDTH-1:0] araddr;
   logic [7:0]                arlen;
   logic [2:0]                arsize;
   logic [1:0]                arburst;
   logic                      arvalid;
   logic                      arready;
   logic [AXI_DATA_WIDTH-1:0] rdata;
   logic [1:0]                rresp;
   logic                      rlast;
   logic                      rvalid;
   logic                      rready;
   logic [PIXEL_WIDTH-1:0]    m_axis_tdata;
   logic                      m_axis_tvalid;
   logic                      m_axis_tready;
   logic                      m_axis_tuser;
   logic                      m_axis_tlast;
   logic                      busy;
   logic                      frame_done;
   logic                      rresp_err;

   axi_to_video_reader #(
      .AXI_DATA_WIDTH(AXI_DATA_WIDTH),
      .PIXEL_WIDTH   (PIXEL_WIDTH),
      .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
      .BURST_LEN     (BURST_LEN),
      .FRAME_PIXELS  (FRAME_PIXELS),
      .FIFO_DEPTH    (FIFO_DEPTH)
   ) dut (
      .axis_video_aclk   (clk),
      .axis_video_aresetn(aresetn),
      .start             (start),
      .frame_base_addr   (frame_base_addr),
      .araddr            (araddr),
      .arlen             (arlen),
      .arsize            (arsize),
      .arburst           (arburst),
      .arvalid           (arvalid),
      .arready           (arready),
      .rdata             (rdata),
      .rresp             (rresp),
      .rlast             (rlast),
      .rvalid            (rvalid),
      .rready            (rready),
      .m_axis_tdata      (m_axis_tdata),
      .m_axis_tvalid     (m_axis_tvalid),
      .m_axis_tready     (m_axis_tready),
      .m_axis_tuser      (m_axis_tuser),
      .m_axis_tlast      (m_axis_tlast),
      .busy              (busy),
      .frame_done        (frame_done),
      .rresp_err         (rresp_err)
   );

   // ---------------- model state ----------------
   logic [31:0]            mem_w [MEM_WORDS];
   logic [PIXEL_WIDTH-1:0] exp_q [$];
   int          n_cmp;
   int          n_fail;
   bit          in_frame;
   bit          exp_err;
   int          occ;
   int          pix_idx;
   int          pix_out;
   int          ar_cnt;
   int          done_seen;
   logic [31:0] cur_base;
   bit          r_pending;
   logic [31:0] r_addr;
   int          r_left;
   int          gbeat;
   // stimulus knobs
   int          ar_wait;
   int          ar_delay;
   int          stall;
   bit          rv_rand;
   bit          t_rand;
   int          err_beat;
   int          restart_mode;
   logic [31:0] restart_base;
   // stability tracking
   bit                     ar_hold;
   bit                     t_hold;
   logic [31:0]            hold_addr;
   logic [PIXEL_WIDTH-1:0] hold_data;
   logic                   hold_user;
   logic                   hold_last;

   // ---------------- scoreboard helpers ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int widx(input logic [31:0] a);
      return int'(((a - MEM_BASE) >> 2) & 32'h0000_0FFF);
   endfunction

   task automatic reset_model();
      exp_q.delete();
      in_frame  = 1'b0;
      exp_err   = 1'b0;
      occ       = 0;
      pix_idx   = 0;
      pix_out   = 0;
      ar_cnt    = 0;
      done_seen = 0;
      cur_base  = '0;
      r_pending = 1'b0;
      r_addr    = '0;
      r_left    = 0;
      gbeat     = 0;
      ar_wait   = 0;
      ar_hold   = 1'b0;
      t_hold    = 1'b0;
      arready   = 1'b0;
      rvalid    = 1'b0;
      rlast     = 1'b0;
      rresp     = 2'b00;
   endtask

   task automatic check_reset(input string pfx);
      chk({pfx, "_arvalid"},    64'(arvalid),       64'(1'b0));
      chk({pfx, "_rready"},     64'(rready),        64'(1'b0));
      chk({pfx, "_tvalid"},     64'(m_axis_tvalid), 64'(1'b0));
      chk({pfx, "_tuser"},      64'(m_axis_tuser),  64'(1'b0));
      chk({pfx, "_tlast"},      64'(m_axis_tlast),  64'(1'b0));
      chk({pfx, "_busy"},       64'(busy),          64'(1'b0));
      chk({pfx, "_frame_done"}, 64'(frame_done),    64'(1'b0));
      chk({pfx, "_rresp_err"},  64'(rresp_err),     64'(1'b0));
      chk({pfx, "_araddr"},     64'(araddr),        64'(32'h0));
      chk({pfx, "_arlen"},      64'(arlen),         64'(BURST_LEN - 1));
      chk({pfx, "_arsize"},     64'(arsize),        64'(2));
      chk({pfx, "_arburst"},    64'(arburst),       64'(2'b01));
   endtask

   // ---------------- driver: one clock cycle ----------------
   // Drive inputs after the falling edge, then check what the next rising edge will do.
   task automatic tick(input logic st);
      bit ar_fire;
      bit r_fire;
      bit p_fire;
      bit acc;
      bit exp_done;
      logic [PIXEL_WIDTH-1:0] e;
      @(negedge clk);
      start = st;
      if (arvalid) begin
         arready = (ar_wait >= ar_delay);
         ar_wait = arready ? 0 : ar_wait + 1;
      end else begin
         arready = 1'b0;
      end
      if (r_pending && (!rv_rand || ($urandom_range(0, 1) == 1))) begin
         rvalid = 1'b1;
         rdata  = mem_w[widx(r_addr)];
         rresp  = (gbeat == err_beat) ? 2'b10 : 2'b00;
         rlast  = (r_left == 1);
      end else begin
         rvalid = 1'b0;
         rdata  = $urandom;
         rresp  = 2'($urandom_range(0, 3));
         rlast  = 1'($urandom_range(0, 1));
      end
      if (stall > 0) begin
         m_axis_tready = 1'b0;
         stall--;
      end else begin
         m_axis_tready = t_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (restart_mode == 1 && m_axis_tvalid && m_axis_tready && pix_idx == FRAME_PIXELS - 1) begin
         frame_base_addr = restart_base;
         start = 1'b1;
         restart_mode = 2;
      end else if (restart_mode == 2) begin
         frame_base_addr = restart_base;
         start = 1'b1;
         restart_mode = 0;
      end
      #1;
      ar_fire  = arvalid && arready;
      r_fire   = rvalid && rready;
      p_fire   = m_axis_tvalid && m_axis_tready;
      acc      = start && !in_frame;
      exp_done = p_fire && (pix_idx == FRAME_PIXELS - 1);

      chk("busy",      64'(busy),          64'(in_frame));
      chk("tvalid",    64'(m_axis_tvalid), 64'(occ != 0));
      chk("rready",    64'(rready),        64'(r_pending));
      chk("rresp_err", 64'(rresp_err),     64'(exp_err));
      chk("frame_done", 64'(frame_done),   64'(exp_done));
      if (!m_axis_tvalid) begin
         chk("sideband_idle", 64'({m_axis_tuser, m_axis_tlast}), 64'(2'b00));
      end
      if (ar_hold) begin
         chk("arvalid_hold", 64'(arvalid), 64'(1'b1));
         chk("araddr_hold",  64'(araddr),  64'(hold_addr));
      end
      if (t_hold) begin
         chk("tdata_hold", 64'(m_axis_tdata), 64'(hold_data));
         chk("tuser_hold", 64'(m_axis_tuser), 64'(hold_user));
         chk("tlast_hold", 64'(m_axis_tlast), 64'(hold_last));
      end
      if (arvalid) begin
         chk("ar_space", 64'(occ <= FIFO_DEPTH - BURST_LEN), 64'(1'b1));
      end
      if (ar_fire) begin
         chk("ar_outstanding", 64'(r_pending), 64'(1'b0));
         chk("araddr",  64'(araddr),  64'(cur_base + 32'(ar_cnt * BURST_BYTES)));
         chk("arlen",   64'(arlen),   64'(BURST_LEN - 1));
         chk("arsize",  64'(arsize),  64'(2));
         chk("arburst", 64'(arburst), 64'(2'b01));
         r_pending = 1'b1;
         r_addr    = araddr;
         r_left    = BURST_LEN;
         ar_cnt++;
      end
      if (r_fire) begin
         if (rresp != 2'b00) exp_err = 1'b1;
         occ++;
         gbeat++;
         r_addr = r_addr + 32'd4;
         r_left--;
         if (r_left == 0) r_pending = 1'b0;
      end
      if (p_fire) begin
         if (exp_q.size() == 0) begin
            chk("pixel_queue_nonempty", 64'(exp_q.size()), 64'd1);
         end else begin
            e = exp_q.pop_front();
            chk("tdata", 64'(m_axis_tdata), 64'(e));
            chk("tuser", 64'(m_axis_tuser), 64'(pix_idx == 0));
            chk("tlast", 64'(m_axis_tlast), 64'(pix_idx == FRAME_PIXELS - 1));
         end
         occ--;
         pix_out++;
         pix_idx = (pix_idx == FRAME_PIXELS - 1) ? 0 : pix_idx + 1;
      end
      if (frame_done) done_seen++;
      if (exp_done) in_frame = 1'b0;
      if (acc) begin
         in_frame  = 1'b1;
         exp_err   = 1'b0;
         cur_base  = frame_base_addr;
         ar_cnt    = 0;
         pix_idx   = 0;
         pix_out   = 0;
         gbeat     = 0;
         done_seen = 0;
         exp_q.delete();
         for (int i = 0; i < FRAME_PIXELS; i++) begin
            exp_q.push_back(mem_w[widx(frame_base_addr + 32'(4 * i))][PIXEL_WIDTH-1:0]);
         end
      end
      ar_hold   = arvalid && !arready;
      hold_addr = araddr;
      t_hold    = m_axis_tvalid && !m_axis_tready;
      hold_data = m_axis_tdata;
      hold_user = m_axis_tuser;
      hold_last = m_axis_tlast;
   endtask

   task automatic run(input int n);
      repeat (n) tick(1'b0);
   endtask

   task automatic start_frame(input logic [31:0] base);
      frame_base_addr = base;
      tick(1'b1);
   endtask

   task automatic run_frame(input int budget);
      int n;
      n = 0;
      while (in_frame && n < budget) begin
         tick(1'b0);
         n++;
      end
      chk("frame_timeout",    64'(in_frame),     64'(1'b0));
      chk("frame_done_count", 64'(done_seen),    64'd1);
      chk("ar_count",         64'(ar_cnt),       64'(NUM_BURSTS));
      chk("pixel_count",      64'(pix_out),      64'(FRAME_PIXELS));
      chk("queue_drained",    64'(exp_q.size()), 64'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      aresetn         = 1'b0;
      start           = 1'b0;
      frame_base_addr = '0;
      rdata           = '0;
      m_axis_tready   = 1'b0;
      n_cmp           = 0;
      n_fail          = 0;
      ar_delay        = 0;
      rv_rand         = 1'b0;
      t_rand          = 1'b0;
      err_beat        = -1;
      restart_mode    = 0;
      restart_base    = '0;
      stall           = 0;
      reset_model();
      for (int i = 0; i < MEM_WORDS; i++) mem_w[i] = $urandom;

      // Reset values.
      #1;
      check_reset("init");
      run(3);
      aresetn = 1'b1;
      run(2);

      // Default frame, ideal slave and sink; a start mid-frame must be ignored.
      start_frame(MEM_BASE);
      run(300);
      frame_base_addr = 32'h2000_0000;
      tick(1'b1);
      run_frame(20000);

      // Sink stalled for 200 cycles: only two bursts fit in the FIFO.
      stall = 200;
      start_frame(MEM_BASE + 32'h1000);
      run(199);
      chk("stall_ar_count", 64'(ar_cnt), 64'd2);
      run_frame(20000);

      // Slow arready, random rvalid and random sink backpressure.
      ar_delay = 5;
      rv_rand  = 1'b1;
      t_rand   = 1'b1;
      start_frame(MEM_BASE + 32'h2000);
      run_frame(40000);
      ar_delay = 0;
      rv_rand  = 1'b0;
      t_rand   = 1'b0;

      // Error response on beat 37; start on the frame_done cycle is ignored,
      // start one cycle later is taken and clears the error flag.
      err_beat     = 37;
      restart_mode = 1;
      restart_base = MEM_BASE + 32'h3000;
      start_frame(MEM_BASE);
      run_frame(20000);
      chk("err_sticky", 64'(rresp_err), 64'(1'b1));
      err_beat = -1;
      tick(1'b0);
      run_frame(20000);
      chk("err_cleared", 64'(rresp_err), 64'(1'b0));

      // Reset in the middle of burst 20, then a full frame afterwards.
      start_frame(MEM_BASE + 32'h1000);
      n = 0;
      while (!(ar_cnt == 21 && r_pending && r_left <= 12) && n < 5000) begin
         tick(1'b0);
         n++;
      end
      chk("reach_burst20", 64'(ar_cnt), 64'd21);
      #2;
      aresetn = 1'b0;
      #1;
      check_reset("midrst");
      reset_model();
      run(3);
      aresetn = 1'b1;
      run(2);
      t_rand = 1'b1;
      start_frame(MEM_BASE + 32'h2000);
      run_frame(40000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
